// File: rtl/operand_pair_source.sv
// operand_pair_source: emits half-precision operand pairs (special-case table, then LFSR randoms)
// on two independent stb/ack channels for a programmable number of pairs.
module operand_pair_source #(
  parameter int unsigned COUNT    = 1024,
  parameter bit          SPECIALS = 1'b1,
  parameter logic [15:0] SEED_A   = 16'hACE1,
  parameter logic [15:0] SEED_B   = 16'h1D2B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [15:0] output_a,
  output logic        output_a_stb,
  input  logic        output_a_ack,
  output logic [15:0] output_b,
  output logic        output_b_stb,
  input  logic        output_b_ack,
  output logic [15:0] pair_count,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
  localparam logic [15:0] INIT_A = (SEED_A == 16'h0) ? 16'h0001 : SEED_A;
  localparam logic [15:0] INIT_B = (SEED_B == 16'h0) ? 16'h0001 : SEED_B;
  localparam logic [16:0] LAST = 17'(COUNT);
  localparam logic [7:0][31:0] SPECIAL_TBL = {
    32'h0001_0001, 32'h7BFF_7BFF, 32'h7E00_3C00, 32'h7C00_FC00,
    32'h7C00_3C00, 32'h3C00_BC00, 32'h8000_0000, 32'h0000_0000
  };
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction
  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, cnt_q, cnt_d, lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic        a_stb_q, a_stb_d, b_stb_q, b_stb_d;
  logic [3:0]  idx_q, idx_d;
  logic        use_tbl, pair_done;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a_stb_d  = a_stb_q;
    b_stb_d  = b_stb_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    use_tbl  = SPECIALS && (idx_q < 4'd8);
    // a channel is finished once its stb is already low or is being acked this edge
    pair_done = (~a_stb_q | output_a_ack) & (~b_stb_q | output_b_ack);
    case (state_q)
      IDLE: state_d = ({1'b0, cnt_q} == LAST) ? DONE : enable ? LOAD : IDLE;
      LOAD: begin
        a_d      = use_tbl ? SPECIAL_TBL[idx_q[2:0]][31:16] : lfsr_a_q;
        b_d      = use_tbl ? SPECIAL_TBL[idx_q[2:0]][15:0] : lfsr_b_q;
        idx_d    = idx_q + 4'(use_tbl);
        lfsr_a_d = use_tbl ? lfsr_a_q : lfsr_step(lfsr_a_q);
        lfsr_b_d = use_tbl ? lfsr_b_q : lfsr_step(lfsr_b_q);
        a_stb_d  = 1'b1;
        b_stb_d  = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        a_stb_d = a_stb_q & ~output_a_ack;
        b_stb_d = b_stb_q & ~output_b_ack;
        if (pair_done) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ({1'b0, cnt_q} + 17'd1 == LAST) ? DONE : enable ? LOAD : IDLE;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      a_stb_q  <= 1'b0;
      b_stb_q  <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      lfsr_a_q <= INIT_A;
      lfsr_b_q <= INIT_B;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_stb_q  <= a_stb_d;
      b_stb_q  <= b_stb_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
    end
  end
  assign output_a     = a_q;
  assign output_b     = b_q;
  assign output_a_stb = a_stb_q;
  assign output_b_stb = b_stb_q;
  assign pair_count   = cnt_q;
  assign done         = state_q == DONE;
endmodule

// File: tb/tb_operand_pair_source.sv
// tb_operand_pair_source: three instances (specials COUNT=10, COUNT=0, random COUNT=1000)
// checked against expected pair tables and a sequence/scoreboard model.
module tb_operand_pair_source;
  localparam int N2 = 1000;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic rst0 = 1, en0 = 0, aa0 = 0, ab0 = 0, sa0, sb0, d0;
  logic [15:0] oa0, ob0, pc0;
  logic rst1 = 1, en1 = 1, sa1, sb1, d1;
  logic [15:0] oa1, ob1, pc1;
  logic rst2 = 1, en2 = 0, aa2 = 0, ab2 = 0, sa2, sb2, d2;
  logic [15:0] oa2, ob2, pc2;
  operand_pair_source #(.COUNT(10), .SPECIALS(1)) u0 (
    .clk(clk), .rst(rst0), .enable(en0), .output_a(oa0), .output_a_stb(sa0), .output_a_ack(aa0),
    .output_b(ob0), .output_b_stb(sb0), .output_b_ack(ab0), .pair_count(pc0), .done(d0));
  operand_pair_source #(.COUNT(0), .SPECIALS(1)) u1 (
    .clk(clk), .rst(rst1), .enable(en1), .output_a(oa1), .output_a_stb(sa1), .output_a_ack(1'b1),
    .output_b(ob1), .output_b_stb(sb1), .output_b_ack(1'b1), .pair_count(pc1), .done(d1));
  operand_pair_source #(.COUNT(N2), .SPECIALS(0)) u2 (
    .clk(clk), .rst(rst2), .enable(en2), .output_a(oa2), .output_a_stb(sa2), .output_a_ack(aa2),
    .output_b(ob2), .output_b_stb(sb2), .output_b_ack(ab2), .pair_count(pc2), .done(d2));
  typedef struct { logic [15:0] a, b; } vec_t;
  vec_t vecs[10];
  logic [15:0] exp_a[N2], exp_b[N2];
  int na = 0, nb = 0;
  logic seen1 = 1'b0;
  logic p_sa = 0, p_sb = 0, p_aa = 0, p_ab = 0;
  logic [15:0] p_oa = 0, p_ob = 0;
  // scoreboard for the random instance: every transfer is matched in order against the expected sequence
  always @(negedge clk) begin
    if (sa1 | sb1) seen1 = 1'b1;
    if (rst2) begin
      na = 0;
      nb = 0;
      p_sa = 0;
      p_sb = 0;
    end else begin
      chk("pair_count2", 32'(pc2), 32'((na < nb) ? na : nb));
      if (p_sa && !p_aa) chk("hold_a", {15'd0, sa2, oa2}, {15'd0, 1'b1, p_oa});
      if (p_sb && !p_ab) chk("hold_b", {15'd0, sb2, ob2}, {15'd0, 1'b1, p_ob});
      if (sa2 && aa2) begin
        if (na < N2) chk("data_a", 32'(oa2), 32'(exp_a[na]));
        else chk("extra_a", 32'(na), 32'(N2 - 1));
        na++;
      end
      if (sb2 && ab2) begin
        if (nb < N2) chk("data_b", 32'(ob2), 32'(exp_b[nb]));
        else chk("extra_b", 32'(nb), 32'(N2 - 1));
        nb++;
      end
      {p_sa, p_sb, p_aa, p_ab, p_oa, p_ob} = {sa2, sb2, aa2, ab2, oa2, ob2};
    end
  end
  initial begin
    logic [15:0] sa, sb;
    int t0;
    vecs = '{'{16'h0000, 16'h0000}, '{16'h8000, 16'h0000}, '{16'h3C00, 16'hBC00},
             '{16'h7C00, 16'h3C00}, '{16'h7C00, 16'hFC00}, '{16'h7E00, 16'h3C00},
             '{16'h7BFF, 16'h7BFF}, '{16'h0001, 16'h0001}, '{16'hACE1, 16'h1D2B},
             '{16'hE270, 16'hBA95}};
    sa = 16'hACE1;
    sb = 16'h1D2B;
    for (int i = 0; i < N2; i++) begin
      exp_a[i] = sa;
      exp_b[i] = sb;
      sa = (sa >> 1) ^ (sa[0] ? 16'hB400 : 16'h0000);
      sb = (sb >> 1) ^ (sb[0] ? 16'hB400 : 16'h0000);
    end
    tick();
    tick();
    chk("reset0", {sa0, sb0, d0, oa0, ob0, pc0}, 51'd0);
    chk("reset2", {sa2, sb2, d2, oa2, ob2, pc2}, 51'd0);
    // COUNT = 0 goes straight to DONE
    rst1 = 0;
    chk("cnt0_before", 32'(d1), 32'd0);
    tick();
    chk("cnt0_done", 32'(d1), 32'd1);
    // specials instance: latency, then reset while B is pending in pair 4
    rst0 = 0;
    en0 = 1;
    aa0 = 1;
    ab0 = 1;
    tick();
    chk("latency_edge1", {sa0, sb0}, 2'b00);
    tick();
    chk("latency_edge2", {sa0, sb0}, 2'b11);
    for (int k = 0; k < 20 && pc0 != 16'd3; k++) tick();
    chk("reach_pair3", 32'(pc0), 32'd3);
    ab0 = 0;
    tick();
    chk("pair4_data", {oa0, ob0}, {16'h7C00, 16'h3C00});
    tick();
    chk("pair4_a_only", {sa0, sb0, pc0}, {1'b0, 1'b1, 16'd3});
    rst0 = 1;
    tick();
    chk("mid_reset", {sa0, sb0, d0, pc0}, 19'd0);
    rst0 = 0;
    ab0 = 1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 10 && !sa0; k++) tick();
      chk($sformatf("vec%0d", i), {sa0, sb0, oa0, ob0}, {2'b11, vecs[i].a, vecs[i].b});
      tick();
    end
    for (int k = 0; k < 10 && !d0; k++) tick();
    chk("done0", {d0, sa0, sb0, pc0}, {3'b100, 16'd10});
    chk("cycles0", 32'(cyc - t0), 32'd21);
    // random instance: B acked late, then enable dropped mid-pair
    rst2 = 0;
    en2 = 1;
    aa2 = 1;
    ab2 = 0;
    for (int k = 0; k < 10 && !sa2; k++) tick();
    chk("r_first", {sa2, sb2, oa2, ob2}, {2'b11, 16'hACE1, 16'h1D2B});
    tick();
    chk("r_a_first", {sa2, sb2, pc2}, {2'b01, 16'd0});
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r_wait_b", {sa2, sb2, pc2}, {2'b01, 16'd0});
    end
    ab2 = 1;
    tick();
    chk("r_b_done", {sb2, pc2}, {1'b0, 16'd1});
    ab2 = 0;
    tick();
    chk("r_pair2", {sa2, sb2, oa2, ob2}, {2'b11, 16'hE270, 16'hBA95});
    en2 = 0;
    tick();
    ab2 = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("r_parked", {sa2, sb2, pc2}, {2'b00, 16'd2});
    end
    en2 = 1;
    tick();
    chk("r_resume1", {sa2, sb2}, 2'b00);
    tick();
    chk("r_resume2", {sa2, sb2, oa2, ob2}, {2'b11, exp_a[2], exp_b[2]});
    for (int k = 0; k < 20000 && !d2; k++) begin
      aa2 = 1'($urandom_range(0, 1));
      ab2 = 1'($urandom_range(0, 1));
      en2 = $urandom_range(0, 7) != 0;
      tick();
    end
    chk("r_done", {d2, pc2}, {1'b1, 16'(N2)});
    @(negedge clk);
    chk("r_xfers", {na[15:0], nb[15:0]}, {16'(N2), 16'(N2)});
    for (int k = 0; k < 4; k++) begin
      en2 = k[0];
      tick();
      chk("r_done_hold", {d2, sa2, sb2, pc2}, {3'b100, 16'(N2)});
    end
    while (cyc < 100) tick();
    chk("cnt0_no_stb", 32'(seen1), 32'd0);
    chk("cnt0_final", {d1, pc1}, {1'b1, 16'd0});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
